// File: rtl/lsu_stage_pkg.sv
// Shared encodings for the load/store unit: access size codes, response
// error codes, FSM states and a size-to-byte-count helper.
package lsu_stage_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_ALIGN   = 2'd1;
  localparam logic [1:0] ERR_SIZE    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } lsu_state_e;

  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

endpackage

// File: rtl/lsu_stage_lane.sv
// Big-endian lane steering: places store data into byte lanes with enables,
// and extracts/extends load data from the same lanes.
module lsu_lane import lsu_stage_pkg::*; #(
  parameter  int DATA_W = 32,
  localparam int NB     = DATA_W / 8,
  localparam int OFF_W  = $clog2(NB)
) (
  input  logic [OFF_W-1:0]  i_off,
  input  logic [1:0]        i_size,
  input  logic              i_signed,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [DATA_W-1:0] i_rdata,
  output logic [DATA_W-1:0] o_wdata,
  output logic [NB-1:0]     o_be,
  output logic [DATA_W-1:0] o_rdata
);

  logic [3:0] w_nb;
  logic       w_fits;
  logic       w_top;

  assign w_nb   = size_bytes(i_size);
  assign w_fits = (int'(w_nb) <= NB);
  // Offset 0 is the most-significant byte, so the field's MSB is lane i_off's top bit.
  assign w_top  = i_rdata[8*(NB-1-int'(i_off)) + 7];

  // Store: low-order field bytes go MSB-first into offsets off..off+nb-1.
  always_comb begin
    o_wdata = '0;
    o_be    = '0;
    for (int i = 0; i < NB; i++) begin
      if (w_fits && (i >= int'(i_off)) && (i < int'(i_off) + int'(w_nb))) begin
        o_be[i] = 1'b1;
        o_wdata[8*(NB-1-i) +: 8] = i_wdata[8*(int'(w_nb)-1-(i-int'(i_off))) +: 8];
      end else begin
        o_be[i] = 1'b0;
      end
    end
  end

  // Load: gather the same lanes right-justified; the wrap mask only matters
  // for misaligned combinations that never reach a response.
  always_comb begin
    o_rdata = '0;
    for (int j = 0; j < NB; j++) begin
      if (w_fits && (j < int'(w_nb))) begin
        o_rdata[8*j +: 8] =
          i_rdata[8*((NB - int'(i_off) - int'(w_nb) + j) & (NB - 1)) +: 8];
      end else if (w_fits) begin
        o_rdata[8*j +: 8] = {8{i_signed & w_top}};
      end else begin
        o_rdata[8*j +: 8] = 8'h00;
      end
    end
  end

endmodule

// File: rtl/lsu_stage.sv
// Memory-stage load/store unit: sized, aligned, big-endian accesses over a
// variable-latency req/ack handshake with a watchdog; stalls while busy.
module lsu_stage import lsu_stage_pkg::*; #(
  parameter  int DATA_W   = 32,
  parameter  int ADDR_W   = 32,
  parameter  int MAX_WAIT = 255,
  localparam int NB       = DATA_W / 8,
  localparam int OFF_W    = $clog2(NB)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [1:0]        rsp_err,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [NB-1:0]     mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int         CNT_W  = $clog2(MAX_WAIT + 1);
  localparam logic [2:0] MAX_SZ = 3'(OFF_W);

  lsu_state_e r_state;
  lsu_state_e w_next;

  logic [CNT_W-1:0]  r_cnt;
  logic [OFF_W-1:0]  r_off;
  logic [1:0]        r_size;
  logic              r_signed;
  logic              r_write;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic [1:0]        r_rsp_err;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [NB-1:0]     r_mem_be;
  logic [DATA_W-1:0] r_mem_wdata;

  logic              w_size_bad;
  logic [2:0]        w_amask;
  logic              w_misalign;
  logic [1:0]        w_req_err;
  logic              w_timeout;
  logic [OFF_W-1:0]  w_lane_off;
  logic [1:0]        w_lane_size;
  logic              w_lane_signed;
  logic [DATA_W-1:0] w_lane_wdata;
  logic [NB-1:0]     w_lane_be;
  logic [DATA_W-1:0] w_lane_rdata;

  assign w_size_bad = ({1'b0, req_size} > MAX_SZ);
  assign w_amask    = 3'(size_bytes(req_size) - 4'd1);
  assign w_misalign = |(req_addr[2:0] & w_amask);
  assign w_req_err  = w_size_bad ? ERR_SIZE : (w_misalign ? ERR_ALIGN : ERR_OK);
  assign w_timeout  = (r_cnt == CNT_W'(MAX_WAIT));

  // The lane block sees the live request while idle and the latched one afterwards.
  assign w_lane_off    = (r_state == ST_IDLE) ? req_addr[OFF_W-1:0] : r_off;
  assign w_lane_size   = (r_state == ST_IDLE) ? req_size : r_size;
  assign w_lane_signed = (r_state == ST_IDLE) ? req_signed : r_signed;

  lsu_lane #(.DATA_W(DATA_W)) u_lane (
    .i_off    (w_lane_off),
    .i_size   (w_lane_size),
    .i_signed (w_lane_signed),
    .i_wdata  (req_wdata),
    .i_rdata  (mem_rdata),
    .o_wdata  (w_lane_wdata),
    .o_be     (w_lane_be),
    .o_rdata  (w_lane_rdata)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          w_next = (w_req_err != ERR_OK) ? ST_RESP : ST_ACCESS;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (mem_ack || w_timeout) begin
          w_next = ST_RESP;
        end else begin
          w_next = ST_ACCESS;
        end
      end
      ST_RESP: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded straight from the state.
  always_comb begin
    req_ready = 1'b0;
    stall     = 1'b0;
    case (r_state)
      ST_IDLE:   req_ready = 1'b1;
      ST_ACCESS: stall     = 1'b1;
      ST_RESP:   req_ready = 1'b0;
      default:   req_ready = 1'b0;
    endcase
  end

  // Request latching, memory drive, watchdog and response registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt       <= '0;
      r_off       <= '0;
      r_size      <= 2'd0;
      r_signed    <= 1'b0;
      r_write     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= ERR_OK;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_be    <= '0;
      r_mem_wdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_rsp_valid <= 1'b0;
          if (req_valid) begin
            r_off    <= req_addr[OFF_W-1:0];
            r_size   <= req_size;
            r_signed <= req_signed;
            r_write  <= req_write;
            r_cnt    <= '0;
            if (w_req_err != ERR_OK) begin
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= w_req_err;
              r_rsp_rdata <= '0;
            end else begin
              r_mem_req   <= 1'b1;
              r_mem_we    <= req_write;
              r_mem_addr  <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
              r_mem_be    <= w_lane_be;
              r_mem_wdata <= req_write ? w_lane_wdata : '0;
            end
          end
        end
        ST_ACCESS: begin
          if (mem_ack) begin
            r_mem_req   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= ERR_OK;
            r_rsp_rdata <= r_write ? '0 : w_lane_rdata;
          end else if (w_timeout) begin
            r_mem_req   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= ERR_TIMEOUT;
            r_rsp_rdata <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_RESP: r_rsp_valid <= 1'b0;
        default: r_rsp_valid <= 1'b0;
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_be    = r_mem_be;
  assign mem_wdata = r_mem_wdata;

endmodule
